alu_divider: RTL and testbench
==============================

# alu_divider

Sequential unsigned restoring divider for the 8-bit ALU datapath. It is launched by the control unit's one-cycle divide-start pulse and returns quotient and remainder. Its one-cycle `done` pulse tells the control unit to leave its wait state. One quotient bit is resolved per clock; divide-by-zero is detected and short-circuited.

## Interface
- `WIDTH`, 8: operand, quotient and remainder width in bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; while low, all state and outputs are held at reset values.
- `start`  in  1  divide request, driven by the control unit's divide-start pulse; sampled only in IDLE.
- `dividend`  in  WIDTH  unsigned dividend; sampled on the accepting edge only.
- `divisor`  in  WIDTH  unsigned divisor; sampled on the accepting edge only.
- `quotient`  out  WIDTH  registered result; holds until the next completion.
- `remainder`  out  WIDTH  registered result; holds until the next completion.
- `div_by_zero`  out  1  set with `done` when divisor was 0; holds until the next completion.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: iterating.
- Internal registers:
  - `R`: partial remainder, WIDTH+1 bits.
  - `Q`: dividend/quotient shift register, WIDTH bits.
  - `D`: latched divisor, WIDTH bits.
  - `cnt`: iteration counter, 0..WIDTH.
- IDLE with `start`=1 and `divisor`≠0:
  - Load R←0, Q←dividend, D←divisor, cnt←WIDTH.
  - Go to RUN.
- IDLE with `start`=1 and `divisor`=0:
  - On that edge: quotient←all ones, remainder←dividend, div_by_zero←1, done←1.
  - Stay in IDLE.
- RUN, each edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}; Q←{Q[WIDTH-2:0], 0}.
  - If T ≥ {0,D}: R←T−{0,D} and Q[0]←1. Otherwise R←T.
  - cnt←cnt−1.
- RUN, edge where cnt=1 (final iteration):
  - quotient←final Q; remainder←final R[WIDTH-1:0].
  - div_by_zero←0, done←1.
  - Go to IDLE.
- `done` defaults to 0 on every edge unless set above.
- `start` in RUN is ignored: no restart, no queueing.
- Operand changes after the accepting edge have no effect.
- Unsigned arithmetic throughout:
  - R never exceeds D after a step.
  - Invariant on completion: dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Reset values: quotient=0, remainder=0, div_by_zero=0, busy=0, done=0, state=IDLE, cnt=0, R=Q=D=0.
- Nonzero divisor:
  - `start` accepted at edge E0.
  - `busy` high from after E0 through edge E_WIDTH.
  - `done` high for exactly the cycle after E_WIDTH (8 cycles after acceptance for WIDTH=8).
  - quotient/remainder valid in that same cycle.
- Zero divisor: `done` and results in the cycle after E0 (latency 1); `busy` never asserts.
- Back-to-back requests:
  - A new `start` is accepted in the cycle `done` is high, since the block is in IDLE then.
  - A `start` held high continuously restarts each time IDLE is reached.
- Reset mid-operation:
  - Asynchronous reset returns all registers to reset values immediately.
  - No `done` is produced for the aborted operation.
- Results and div_by_zero change only on a completion edge (or reset); they are stable for the control unit at all other times.

## Test plan
- Reset release, no start:
  - All outputs 0 and busy=0 for 20 cycles.
- 200 ÷ 7:
  - busy high 8 cycles.
  - done pulse 8 cycles after acceptance, exactly 1 cycle wide.
  - quotient=28, remainder=4, div_by_zero=0.
- Edge operands:
  - 255 ÷ 1 → 255 r 0.
  - 5 ÷ 9 → 0 r 5.
  - 0 ÷ 3 → 0 r 0.
  - 255 ÷ 255 → 1 r 0.
- 37 ÷ 0:
  - done in the next cycle; busy never high.
  - quotient=255, remainder=37, div_by_zero=1.
  - A following 9 ÷ 3 clears div_by_zero and gives 3 r 0.
- Start while busy:
  - 100 ÷ 3 accepted; `start` pulsed with 50 ÷ 5 at cycle 4.
  - Ignored: one done only, 33 r 1.
  - A second request in the done cycle completes 8 cycles later.
- Reset mid-operation:
  - rst low at cycle 3 of 200 ÷ 7 → outputs 0 asynchronously, no done.
  - After release, 200 ÷ 7 again gives 28 r 4.
- Randomized check: 1000 random pairs against the invariant and a reference model.

Source files
------------

// File: rtl/alu_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with a
// single-cycle short-circuit for a zero divisor.
module alu_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  // Partial remainder never exceeds the divisor after a step, so its top bit
  // is always zero and only WIDTH bits are stored.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;

  always_comb begin
    trial = {r_q, q_q[WIDTH-1]};
    diff  = trial - {1'b0, d_q};
    fits  = trial >= {1'b0, d_q};
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d  = '1;
            rem_d  = dividend;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            r_d     = '0;
            q_d     = dividend;
            d_d     = divisor;
            cnt_d   = CntW'(WIDTH);
            state_d = StRun;
          end
        end
      end
      StRun: begin
        r_d   = WIDTH'(fits ? diff : trial);
        q_d   = {q_q[WIDTH-2:0], fits};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          quo_d   = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == StRun);
  assign done        = done_q;

endmodule

// File: tb/tb_alu_divider.sv
// Bench for alu_divider: directed vector table, hand-written corner sequences
// and randomized operands checked against plain integer division.
module tb_alu_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;
  logic         done;

  int n_tests;
  int n_fail;

  alu_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Presents a request and returns #1 after the accepting edge with start low
  // and the operand inputs scrambled.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit now);
    if (!now) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Counts clock edges after acceptance until done is seen (sampled at negedge).
  task automatic wait_done(output int edges, output int busy_cnt, output bit ok);
    edges    = 0;
    busy_cnt = 0;
    ok       = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
      else begin
        edges++;
        if (busy) busy_cnt++;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: done not seen within 20 cycles");
    end
  endtask

  initial begin
    int           edges;
    int           bcnt;
    bit           ok;
    int           first;
    int           second;
    int           ndone;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    logic [W-1:0] held_q;

    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  z: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  z: 1'b0};
    vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  z: 1'b0};
    vecs[3] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  z: 1'b0};
    vecs[4] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  z: 1'b0};
    vecs[5] = '{a: 8'd37,  b: 8'd0,   q: 8'd255, r: 8'd37, z: 1'b1};
    vecs[6] = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,  z: 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Idle after reset release: every output stays zero.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_idle_outputs", {quotient, remainder, div_by_zero, busy, done}, '0);
    end

    // Directed vectors.
    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, 1'b0);
      wait_done(edges, bcnt, ok);
      if (ok) begin
        check("vec_quotient",  quotient,    vecs[i].q);
        check("vec_remainder", remainder,   vecs[i].r);
        check("vec_dbz",       div_by_zero, vecs[i].z);
        check("vec_latency",   edges,       (vecs[i].b == 0) ? 0 : W);
        check("vec_busy_cycles", bcnt,      (vecs[i].b == 0) ? 0 : W);
        check("vec_busy_at_done", busy,     0);
        @(negedge clk);
        check("vec_done_width", done, 0);
      end
    end

    // Start while busy is ignored; a request in the done cycle is accepted.
    launch(8'd100, 8'd3, 1'b0);
    repeat (3) @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    ndone    = 0;
    for (int i = 0; i < 20 && ndone == 0; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("busy_start_done_seen", ndone, 1);
    check("busy_start_quotient",  quotient,  33);
    check("busy_start_remainder", remainder, 1);
    launch(8'd50, 8'd5, 1'b1);
    wait_done(edges, bcnt, ok);
    if (ok) begin
      check("b2b_latency",   edges,     W);
      check("b2b_quotient",  quotient,  10);
      check("b2b_remainder", remainder, 0);
    end
    @(negedge clk);

    // Held start restarts each time IDLE is reached.
    dividend = 8'd12;
    divisor  = 8'd4;
    start    = 1'b1;
    first    = -1;
    second   = -1;
    held_q   = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) begin
          first  = i;
          held_q = quotient;
        end else if (second < 0) begin
          second = i;
        end
      end
    end
    start = 1'b0;
    check("held_start_gap", second - first, W + 1);
    check("held_start_quotient", held_q, 3);
    wait_done(edges, bcnt, ok);
    @(negedge clk);

    // Asynchronous reset in the middle of 200 / 7.
    launch(8'd200, 8'd7, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_reset_outputs", {quotient, remainder, div_by_zero, busy, done}, '0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("aborted_no_done", ndone, 0);
    launch(8'd200, 8'd7, 1'b0);
    wait_done(edges, bcnt, ok);
    if (ok) begin
      check("after_reset_quotient",  quotient,  28);
      check("after_reset_remainder", remainder, 4);
    end

    // Randomized operands against plain integer division.
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = (i % 50 == 0) ? '0 : W'($urandom);
      if (b == 0) begin
        eq = '1;
        er = a;
        ez = 1'b1;
      end else begin
        eq = a / b;
        er = a % b;
        ez = 1'b0;
      end
      launch(a, b, 1'b0);
      wait_done(edges, bcnt, ok);
      if (ok) begin
        check("rand_quotient",  quotient,    eq);
        check("rand_remainder", remainder,   er);
        check("rand_dbz",       div_by_zero, ez);
        if (b != 0)
          check("rand_invariant",
                ((int'(quotient) * int'(b) + int'(remainder)) == int'(a)) && (remainder < b), 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
